vga_term_writer: RTL and testbench

VGA_TERM_WRITER -- requirements
Module: vga_term_writer

---
 rtl/vga_term_writer_if.sv | 29 ++
 rtl/vga_term_writer.sv | 168 ++++++++++++++++
 tb/tb_vga_term_writer.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_term_writer_if.sv
//------------------------------------------------------------------------------
// Module  : vga_term_writer_if
// Purpose : Terminal character input and video-RAM write port bundle.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface vga_term_writer_if;
  logic [6:0] char_in;
  logic       char_valid;
  logic       char_ready;
  logic       clr_screen;
  logic [9:0] vram_waddr;
  logic [5:0] vram_din;
  logic       vram_wen;
  logic [4:0] top_row;

  modport master (
    output char_in, char_valid, clr_screen,
    input  char_ready, vram_waddr, vram_din, vram_wen, top_row
  );

  modport slave (
    input  char_in, char_valid, clr_screen,
    output char_ready, vram_waddr, vram_din, vram_wen, top_row
  );
endinterface

`default_nettype wire

// File: rtl/vga_term_writer.sv
//------------------------------------------------------------------------------
// Module  : vga_term_writer
// Purpose : Writes terminal characters into a scrolling VRAM text screen.
//           Optional cursor drawing enabled by macro TERM_CURSOR_EN.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module vga_term_writer #(
  parameter int COLS = 40,
  parameter int ROWS = 24
) (
  input  wire logic        clk,
  input  wire logic        rst,
  vga_term_writer_if.slave bus
);

  localparam int              c_CW          = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [c_CW-1:0] c_COL_LAST    = c_CW'(COLS - 1);
  localparam logic [4:0]      c_ROW_LAST    = 5'(ROWS - 1);
  localparam logic [9:0]      c_CELL_LAST   = 10'(COLS * ROWS - 1);
  localparam logic [5:0]      c_SPACE       = 6'h20;
  localparam logic [5:0]      c_CURSOR_CHAR = 6'h00;

  localparam logic [2:0] c_IDLE       = 3'd0;
  localparam logic [2:0] c_WRITE      = 3'd1;
  localparam logic [2:0] c_NEWLINE    = 3'd2;
  localparam logic [2:0] c_CLEAR_LINE = 3'd3;
  localparam logic [2:0] c_CLEAR_ALL  = 3'd4;
  localparam logic [2:0] c_CURSOR     = 3'd5;

`ifdef TERM_CURSOR_EN
  localparam logic [2:0] c_DONE = c_CURSOR;
`else
  localparam logic [2:0] c_DONE = c_IDLE;
`endif

  logic [2:0]      r_state;
  logic [c_CW-1:0] r_col;
  logic [4:0]      r_prow;
  logic [4:0]      r_lrow;
  logic [4:0]      r_top;
  logic [9:0]      r_cnt;
  logic [5:0]      r_glyph;

  logic            w_take;
  logic            w_printable;
  logic [5:0]      w_glyph;
  logic [4:0]      w_prow_next;
  logic [4:0]      w_top_next;
  logic [9:0]      w_line_base;
  logic [9:0]      w_cur_addr;

  assign bus.char_ready = (r_state == c_IDLE) & ~rst & ~bus.clr_screen;
  assign bus.top_row    = r_top;

  assign w_take      = bus.char_valid & bus.char_ready;
  assign w_printable = bus.char_in[6] | bus.char_in[5];
  // 0x20-0x5F keep their low six bits; 0x60-0x7F minus 0x20 lands on 0b0xxxxx
  assign w_glyph     = {bus.char_in[5] & ~bus.char_in[6], bus.char_in[4:0]};

  assign w_prow_next = (r_prow == c_ROW_LAST) ? 5'd0 : r_prow + 5'd1;
  assign w_top_next  = (r_top  == c_ROW_LAST) ? 5'd0 : r_top  + 5'd1;
  assign w_line_base = 10'(r_prow) * 10'(COLS);
  assign w_cur_addr  = w_line_base + 10'(r_col);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_IDLE;
      r_col   <= '0;
      r_prow  <= '0;
      r_lrow  <= '0;
      r_top   <= '0;
      r_cnt   <= '0;
      r_glyph <= '0;
    end else if (bus.clr_screen) begin
      r_state <= c_CLEAR_ALL;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_take) begin
            if (w_printable) begin
              r_glyph <= w_glyph;
              r_state <= c_WRITE;
            end else if (bus.char_in == 7'h0D) begin
              r_state <= c_NEWLINE;
            end
          end
        end
        c_WRITE: begin
          if (r_col == c_COL_LAST) begin
            r_state <= c_NEWLINE;
          end else begin
            r_col   <= r_col + c_CW'(1);
            r_state <= c_DONE;
          end
        end
        c_NEWLINE: begin
          r_col  <= '0;
          r_prow <= w_prow_next;
          if (r_lrow != c_ROW_LAST) begin
            r_lrow  <= r_lrow + 5'd1;
            r_state <= c_DONE;
          end else begin
            // Bottom reached: the screen scrolls and the recycled row is blanked
            r_top   <= w_top_next;
            r_state <= c_CLEAR_LINE;
          end
        end
        c_CLEAR_LINE: begin
          if (r_col == c_COL_LAST) begin
            r_col   <= '0;
            r_state <= c_DONE;
          end else begin
            r_col <= r_col + c_CW'(1);
          end
        end
        c_CLEAR_ALL: begin
          if (r_cnt == c_CELL_LAST) begin
            r_cnt   <= '0;
            r_col   <= '0;
            r_prow  <= '0;
            r_lrow  <= '0;
            r_top   <= '0;
            r_state <= c_DONE;
          end else begin
            r_cnt <= r_cnt + 10'd1;
          end
        end
        c_CURSOR: r_state <= c_IDLE;
        default:  r_state <= c_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.vram_wen   = 1'b0;
    bus.vram_waddr = '0;
    bus.vram_din   = '0;
    case (r_state)
      c_WRITE: begin
        bus.vram_wen   = 1'b1;
        bus.vram_waddr = w_cur_addr;
        bus.vram_din   = r_glyph;
      end
      c_CLEAR_LINE: begin
        bus.vram_wen   = 1'b1;
        bus.vram_waddr = w_cur_addr;
        bus.vram_din   = c_SPACE;
      end
      c_CLEAR_ALL: begin
        bus.vram_wen   = 1'b1;
        bus.vram_waddr = r_cnt;
        bus.vram_din   = c_SPACE;
      end
      c_CURSOR: begin
        bus.vram_wen   = 1'b1;
        bus.vram_waddr = w_cur_addr;
        bus.vram_din   = c_CURSOR_CHAR;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_vga_term_writer.sv
//------------------------------------------------------------------------------
// Module  : tb_vga_term_writer
// Purpose : Scoreboard bench for vga_term_writer (honours TERM_CURSOR_EN).
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_vga_term_writer;
  localparam int COLS = 40;
  localparam int ROWS = 24;
`ifdef TERM_CURSOR_EN
  localparam int CUR = 1;
`else
  localparam int CUR = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  vga_term_writer_if bus ();

  vga_term_writer #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] exp_q[$];
  bit          done  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int a, input int d);
    exp_q.push_back({a[9:0], d[5:0]});
  endtask

  task automatic push_cur(input int a);
    if (CUR != 0) push(a, 0);
  endtask

  task automatic exp_clear_all();
    for (int i = 0; i < COLS * ROWS; i++) push(i, 'h20);
    push_cur(0);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (bus.char_ready !== 1'b1 && n < 3000) begin
      tick();
      n++;
    end
    chk("ready_wait", bus.char_ready, 1);
  endtask

  task automatic send(input logic [6:0] c);
    wait_ready();
    bus.char_in    = c;
    bus.char_valid = 1'b1;
    tick();
    bus.char_valid = 1'b0;
  endtask

  task automatic count_low(output int n);
    n = 0;
    while (bus.char_ready !== 1'b1 && n < 3000) begin
      tick();
      n++;
    end
  endtask

  task automatic monitor();
    logic [15:0] e;
    while (!done) begin
      @(negedge clk);
      if (bus.vram_wen === 1'b1) begin
        chk("addr_range", 32'(bus.vram_waddr <= 10'd959), 1);
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_write: addr %0d din %0h, expected no write",
                   bus.vram_waddr, bus.vram_din);
        end else begin
          e = exp_q.pop_front();
          chk("waddr", bus.vram_waddr, e[15:6]);
          chk("wdin", bus.vram_din, e[5:0]);
        end
      end
    end
  endtask

  task automatic stimulus();
    int         n;
    logic [6:0] chars [5] = '{7'h5A, 7'h7E, 7'h20, 7'h5F, 7'h7F};
    logic [5:0] glyphs[5] = '{6'h1A, 6'h1E, 6'h20, 6'h1F, 6'h1F};
    logic [6:0] c;

    repeat (3) tick();
    chk("rst_ready", bus.char_ready, 0);
    chk("rst_wen", bus.vram_wen, 0);
    chk("rst_waddr", bus.vram_waddr, 0);
    chk("rst_din", bus.vram_din, 0);
    chk("rst_top", bus.top_row, 0);
    rst = 1'b0;
    #1;
    chk("ready_after_release", bus.char_ready, 1);

    // 'A', CR, 'a', then discarded control codes and a glyph table
    push(0, 1); push_cur(1);
    send(7'h41); count_low(n);
    chk("A_ready_low", n, 1 + CUR);
    push_cur(40);
    send(7'h0D); count_low(n);
    chk("cr_ready_low", n, 1 + CUR);
    push(40, 1); push_cur(41);
    send(7'h61);
    wait_ready();
    send(7'h07);
    chk("bell_ready", bus.char_ready, 1);
    send(7'h00);
    send(7'h1F);
    chk("ctl_ready", bus.char_ready, 1);
    for (int i = 0; i < 5; i++) begin
      push(41 + i, glyphs[i]); push_cur(42 + i);
      send(chars[i]);
    end
    wait_ready();
    chk("top_row0", bus.top_row, 0);

    // clear request together with a character: char dropped
    exp_clear_all();
    bus.char_in    = 7'h58;
    bus.char_valid = 1'b1;
    bus.clr_screen = 1'b1;
    #1;
    chk("clr_blocks_ready", bus.char_ready, 0);
    tick();
    bus.char_valid = 1'b0;
    bus.clr_screen = 1'b0;
    wait_ready();
    chk("top_after_clr", bus.top_row, 0);

    // full row of printables wraps to row 1 without a clear
    for (int i = 0; i < COLS; i++) begin
      c = 7'h41 + 7'(i % 26);
      push(i, c[5:0]); push_cur(i + 1);
      send(c);
    end
    push(40, 2); push_cur(41);
    send(7'h42);
    wait_ready();
    chk("top_after_row", bus.top_row, 0);

    exp_clear_all();
    bus.clr_screen = 1'b1; tick(); bus.clr_screen = 1'b0;
    wait_ready();

    // 23 plain newlines, then the first scroll
    for (int k = 1; k < ROWS; k++) begin
      push_cur(40 * k);
      send(7'h0D);
    end
    wait_ready();
    chk("top_before_scroll", bus.top_row, 0);
    for (int i = 0; i < COLS; i++) push(i, 'h20);
    push_cur(0);
    send(7'h0D); count_low(n);
    chk("scroll_ready_low", n, 41 + CUR);
    chk("top_first_scroll", bus.top_row, 1);

    for (int k = 1; k < ROWS; k++) begin
      for (int i = 0; i < COLS; i++) push(40 * k + i, 'h20);
      push_cur(40 * k);
      send(7'h0D);
      wait_ready();
      chk("scroll_top", bus.top_row, 32'((k + 1) % ROWS));
    end
    // prow 23 -> 0 wrap
    for (int i = 0; i < COLS; i++) push(i, 'h20);
    push_cur(0);
    send(7'h0D);
    wait_ready();
    chk("top_wrap_scroll", bus.top_row, 1);
    push(0, 3); push_cur(1);
    send(7'h43);

    // clear request in the middle of a line clear
    push(40, 'h20); push(41, 'h20); push(42, 'h20);
    exp_clear_all();
    send(7'h0D);
    tick(); tick(); tick();
    chk("top_mid_clear", bus.top_row, 2);
    bus.clr_screen = 1'b1; tick(); bus.clr_screen = 1'b0;
    wait_ready();
    chk("top_after_abort", bus.top_row, 0);
    push(0, 4); push_cur(1);
    send(7'h44);
    push_cur(40);
    send(7'h0D);
    push(40, 5); push_cur(41);
    send(7'h45);
    wait_ready();

    // reset in the middle of a screen clear
    for (int i = 0; i < 4; i++) push(i, 'h20);
    bus.clr_screen = 1'b1; tick(); bus.clr_screen = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    #1;
    chk("rst_mid_wen", bus.vram_wen, 0);
    chk("rst_mid_ready", bus.char_ready, 0);
    repeat (3) tick();
    rst = 1'b0;
    repeat (50) tick();
    chk("ready_after_rst", bus.char_ready, 1);
    chk("top_after_rst", bus.top_row, 0);
    push(0, 6); push_cur(1);
    send(7'h46);
    repeat (5) tick();
    done = 1'b1;
  endtask

  initial begin
    bus.char_in    = '0;
    bus.char_valid = 1'b0;
    bus.clr_screen = 1'b0;
    fork
      monitor();
      stimulus();
    join
    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
